// File: rtl/branch_predictor_pkg.sv
// rtl/branch_predictor_pkg.sv - shared types, default sizes and counter helper for the branch predictor
package branch_predictor_pkg;

   localparam int BHT_ENTRIES_DEF  = 64;
   localparam int GHR_BITS_DEF     = 6;
   localparam int BTB_ENTRIES_DEF  = 16;
   localparam int BTB_TAG_BITS_DEF = 8;

   typedef logic [31:0] ADDR;

   typedef enum logic [1:0] {
      SNT = 2'b00,
      WNT = 2'b01,
      WT  = 2'b10,
      ST  = 2'b11
   } BP_COUNTER;

   typedef struct packed {
      logic                        valid;
      logic [BTB_TAG_BITS_DEF-1:0] tag;
      ADDR                         target;
      logic                        is_cond;
   } BTB_ENTRY;

   // Saturating 2-bit step toward the resolved direction
   function automatic BP_COUNTER counter_next(input BP_COUNTER c, input logic taken);
      case (c)
         SNT:     return taken ? WNT : SNT;
         WNT:     return taken ? WT  : SNT;
         WT:      return taken ? ST  : WNT;
         ST:      return taken ? ST  : WT;
         default: return WNT;
      endcase
   endfunction

endpackage

// File: rtl/branch_predictor_if.sv
// rtl/branch_predictor_if.sv - fetch prediction and resolve training signals
interface branch_predictor_if
   import branch_predictor_pkg::*;
#(
   parameter int GHR_BITS = GHR_BITS_DEF
);
   logic                pred_valid;
   ADDR                 pred_pc;
   logic                pred_taken;
   ADDR                 pred_target;
   logic [GHR_BITS-1:0] pred_ghr;

   logic                resolve_valid;
   ADDR                 resolve_pc;
   logic                resolve_taken;
   ADDR                 resolve_target;
   logic                resolve_is_cond;
   logic [GHR_BITS-1:0] resolve_ghr;
   logic                resolve_mispredict;

   modport master (
      output pred_valid, pred_pc,
      input  pred_taken, pred_target, pred_ghr,
      output resolve_valid, resolve_pc, resolve_taken, resolve_target,
      output resolve_is_cond, resolve_ghr, resolve_mispredict
   );

   modport slave (
      input  pred_valid, pred_pc,
      output pred_taken, pred_target, pred_ghr,
      input  resolve_valid, resolve_pc, resolve_taken, resolve_target,
      input  resolve_is_cond, resolve_ghr, resolve_mispredict
   );
endinterface

// File: rtl/branch_btb.sv
// rtl/branch_btb.sv - direct-mapped tagged BTB, combinational read, one synchronous write
module branch_btb
   import branch_predictor_pkg::*;
#(
   parameter int ENTRIES  = BTB_ENTRIES_DEF,
   parameter int TAG_BITS = BTB_TAG_BITS_DEF
) (
   input  logic i_clock,
   input  logic i_reset,
   input  ADDR  i_rd_pc,
   output logic o_rd_hit,
   output ADDR  o_rd_target,
   output logic o_rd_is_cond,
   input  logic i_wr_en,
   input  ADDR  i_wr_pc,
   input  ADDR  i_wr_target,
   input  logic i_wr_is_cond
);
   localparam int IDX_BITS = $clog2(ENTRIES);

   BTB_ENTRY              r_table [ENTRIES];
   logic [IDX_BITS-1:0]   w_rd_idx;
   logic [IDX_BITS-1:0]   w_wr_idx;
   logic [TAG_BITS-1:0]   w_rd_tag;
   logic [TAG_BITS-1:0]   w_wr_tag;
   BTB_ENTRY              w_rd_entry;
   logic                  w_unused;

   assign w_rd_idx = i_rd_pc[IDX_BITS+1:2];
   assign w_wr_idx = i_wr_pc[IDX_BITS+1:2];
   assign w_rd_tag = i_rd_pc[IDX_BITS+2 +: TAG_BITS];
   assign w_wr_tag = i_wr_pc[IDX_BITS+2 +: TAG_BITS];

   assign w_rd_entry   = r_table[w_rd_idx];
   assign o_rd_hit     = w_rd_entry.valid && (w_rd_entry.tag == w_rd_tag);
   assign o_rd_target  = w_rd_entry.target;
   assign o_rd_is_cond = w_rd_entry.is_cond;

   // Byte offset and PC bits above the tag never take part in lookup
   assign w_unused = &{1'b0, i_rd_pc[1:0], i_wr_pc[1:0],
                       i_rd_pc[31:IDX_BITS+2+TAG_BITS], i_wr_pc[31:IDX_BITS+2+TAG_BITS]};

   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         for (int i = 0; i < ENTRIES; i++) begin
            r_table[i] <= '0;
         end
      end else if (i_wr_en) begin
         r_table[w_wr_idx] <= '{valid: 1'b1, tag: w_wr_tag, target: i_wr_target,
                                is_cond: i_wr_is_cond};
      end
   end

endmodule

// File: rtl/branch_predictor.sv
// rtl/branch_predictor.sv - gshare direction predictor with speculative GHR and BTB target lookup
module branch_predictor
   import branch_predictor_pkg::*;
#(
   parameter int BHT_ENTRIES  = BHT_ENTRIES_DEF,
   parameter int GHR_BITS     = GHR_BITS_DEF,
   parameter int BTB_ENTRIES  = BTB_ENTRIES_DEF,
   parameter int BTB_TAG_BITS = BTB_TAG_BITS_DEF
) (
   input  logic               clock,
   input  logic               reset,
   branch_predictor_if.slave  bp
);
   BP_COUNTER            r_bht [BHT_ENTRIES];
   logic [GHR_BITS-1:0]  r_ghr;

   logic [GHR_BITS-1:0]  w_pred_idx;
   logic [GHR_BITS-1:0]  w_res_idx;
   logic [1:0]           w_pred_ctr;
   logic                 w_btb_hit;
   ADDR                  w_btb_target;
   logic                 w_btb_is_cond;
   logic                 w_pred_taken;
   logic                 w_btb_wr_en;

   assign w_pred_idx = bp.pred_pc[GHR_BITS+1:2] ^ r_ghr;
   assign w_res_idx  = bp.resolve_pc[GHR_BITS+1:2] ^ bp.resolve_ghr;
   assign w_pred_ctr = r_bht[w_pred_idx];

   // Unconditional hits are always taken; conditional hits follow the counter MSB
   assign w_pred_taken   = w_btb_hit && (!w_btb_is_cond || w_pred_ctr[1]);
   assign bp.pred_taken  = w_pred_taken;
   assign bp.pred_target = w_pred_taken ? w_btb_target : bp.pred_pc + 32'd4;
   assign bp.pred_ghr    = r_ghr;

   assign w_btb_wr_en = bp.resolve_valid && bp.resolve_taken;

   branch_btb #(
      .ENTRIES  (BTB_ENTRIES),
      .TAG_BITS (BTB_TAG_BITS)
   ) u_btb (
      .i_clock      (clock),
      .i_reset      (reset),
      .i_rd_pc      (bp.pred_pc),
      .o_rd_hit     (w_btb_hit),
      .o_rd_target  (w_btb_target),
      .o_rd_is_cond (w_btb_is_cond),
      .i_wr_en      (w_btb_wr_en),
      .i_wr_pc      (bp.resolve_pc),
      .i_wr_target  (bp.resolve_target),
      .i_wr_is_cond (bp.resolve_is_cond)
   );

   always_ff @(posedge clock) begin
      if (reset) begin
         for (int i = 0; i < BHT_ENTRIES; i++) begin
            r_bht[i] <= WNT;
         end
      end else if (bp.resolve_valid && bp.resolve_is_cond) begin
         r_bht[w_res_idx] <= counter_next(r_bht[w_res_idx], bp.resolve_taken);
      end
   end

   // Recovery from the branch's checkpoint wins over the same-cycle speculative shift
   always_ff @(posedge clock) begin
      if (reset) begin
         r_ghr <= '0;
      end else if (bp.resolve_valid && bp.resolve_mispredict) begin
         r_ghr <= bp.resolve_is_cond ? {bp.resolve_ghr[GHR_BITS-2:0], bp.resolve_taken}
                                     : bp.resolve_ghr;
      end else if (bp.pred_valid && w_btb_hit && w_btb_is_cond) begin
         r_ghr <= {r_ghr[GHR_BITS-2:0], w_pred_taken};
      end
   end

endmodule

// File: tb/tb_branch_predictor.sv
// tb/tb_branch_predictor.sv - directed vector bench for branch_predictor
module tb_branch_predictor;
   import branch_predictor_pkg::*;

   typedef struct {
      logic        pv;
      logic [31:0] ppc;
      logic        rv;
      logic [31:0] rpc;
      logic        rt;
      logic [31:0] rtgt;
      logic        rc;
      logic [5:0]  rg;
      logic        rm;
      logic        et;
      logic [31:0] etgt;
      logic [5:0]  eg;
   } vec_t;

   logic clock;
   logic reset;
   int   n_cmp;
   int   n_err;
   vec_t vecs [29];

   branch_predictor_if #(.GHR_BITS(6)) bp_if ();

   branch_predictor #(
      .BHT_ENTRIES  (64),
      .GHR_BITS     (6),
      .BTB_ENTRIES  (16),
      .BTB_TAG_BITS (8)
   ) dut (
      .clock (clock),
      .reset (reset),
      .bp    (bp_if)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   function automatic vec_t mk(input logic pv, input logic [31:0] ppc,
                               input logic rv, input logic [31:0] rpc, input logic rt,
                               input logic [31:0] rtgt, input logic rc, input logic [5:0] rg,
                               input logic rm, input logic et, input logic [31:0] etgt,
                               input logic [5:0] eg);
      vec_t v;
      v.pv = pv; v.ppc = ppc; v.rv = rv; v.rpc = rpc; v.rt = rt; v.rtgt = rtgt;
      v.rc = rc; v.rg = rg; v.rm = rm; v.et = et; v.etgt = etgt; v.eg = eg;
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   task automatic drive(input vec_t v);
      bp_if.pred_valid         = v.pv;
      bp_if.pred_pc            = v.ppc;
      bp_if.resolve_valid      = v.rv;
      bp_if.resolve_pc         = v.rpc;
      bp_if.resolve_taken      = v.rt;
      bp_if.resolve_target     = v.rtgt;
      bp_if.resolve_is_cond    = v.rc;
      bp_if.resolve_ghr        = v.rg;
      bp_if.resolve_mispredict = v.rm;
   endtask

   task automatic check_outs(input string tag, input logic et, input logic [31:0] etgt,
                             input logic [5:0] eg);
      check({tag, "_taken"},  {31'b0, bp_if.pred_taken}, {31'b0, et});
      check({tag, "_target"}, bp_if.pred_target, etgt);
      check({tag, "_ghr"},    {26'b0, bp_if.pred_ghr}, {26'b0, eg});
   endtask

   initial begin
      n_cmp = 0;
      n_err = 0;
      // pv ppc | rv rpc rt rtgt rc rg rm | exp taken target ghr
      vecs[0]  = mk(1, 32'h100, 0, 32'h0,   0, 32'h0,   0, 6'd0, 0, 0, 32'h104, 6'd0);
      vecs[1]  = mk(0, 32'h100, 1, 32'h200, 1, 32'h400, 0, 6'd0, 0, 0, 32'h104, 6'd0);
      vecs[2]  = mk(1, 32'h200, 0, 32'h0,   0, 32'h0,   0, 6'd0, 0, 1, 32'h400, 6'd0);
      vecs[3]  = mk(1, 32'h200, 1, 32'h300, 1, 32'h280, 1, 6'd0, 0, 1, 32'h400, 6'd0);
      vecs[4]  = mk(1, 32'h300, 0, 32'h0,   0, 32'h0,   0, 6'd0, 0, 1, 32'h280, 6'd0);
      vecs[5]  = mk(0, 32'h300, 1, 32'h104, 1, 32'h500, 0, 6'd0, 1, 0, 32'h304, 6'd1);
      vecs[6]  = mk(0, 32'h300, 1, 32'h300, 0, 32'h280, 1, 6'd0, 0, 1, 32'h280, 6'd0);
      vecs[7]  = mk(0, 32'h300, 1, 32'h300, 0, 32'h280, 1, 6'd0, 0, 0, 32'h304, 6'd0);
      vecs[8]  = mk(0, 32'h300, 1, 32'h300, 0, 32'h280, 1, 6'd0, 0, 0, 32'h304, 6'd0);
      vecs[9]  = mk(0, 32'h300, 1, 32'h300, 1, 32'h280, 1, 6'd0, 0, 0, 32'h304, 6'd0);
      vecs[10] = mk(1, 32'h300, 1, 32'h300, 1, 32'h280, 1, 6'd0, 0, 0, 32'h304, 6'd0);
      vecs[11] = mk(0, 32'h300, 1, 32'h300, 1, 32'h280, 1, 6'd0, 0, 1, 32'h280, 6'd0);
      vecs[12] = mk(0, 32'h300, 1, 32'h300, 1, 32'h280, 1, 6'd0, 0, 1, 32'h280, 6'd0);
      vecs[13] = mk(0, 32'h300, 1, 32'h300, 0, 32'h280, 1, 6'd0, 0, 1, 32'h280, 6'd0);
      vecs[14] = mk(0, 32'h300, 0, 32'h0,   0, 32'h0,   0, 6'd0, 0, 1, 32'h280, 6'd0);
      vecs[15] = mk(0, 32'h300, 1, 32'h300, 1, 32'h280, 1, 6'd1, 0, 1, 32'h280, 6'd0);
      vecs[16] = mk(0, 32'h300, 1, 32'h300, 1, 32'h280, 1, 6'd3, 0, 1, 32'h280, 6'd0);
      vecs[17] = mk(1, 32'h300, 0, 32'h0,   0, 32'h0,   0, 6'd0, 0, 1, 32'h280, 6'd0);
      vecs[18] = mk(1, 32'h300, 0, 32'h0,   0, 32'h0,   0, 6'd0, 0, 1, 32'h280, 6'd1);
      vecs[19] = mk(1, 32'h300, 0, 32'h0,   0, 32'h0,   0, 6'd0, 0, 1, 32'h280, 6'd3);
      vecs[20] = mk(1, 32'h300, 1, 32'h300, 0, 32'h280, 1, 6'd2, 1, 0, 32'h304, 6'd7);
      vecs[21] = mk(1, 32'h300, 1, 32'h108, 1, 32'h600, 0, 6'd2, 1, 0, 32'h304, 6'd4);
      vecs[22] = mk(0, 32'h300, 0, 32'h0,   0, 32'h0,   0, 6'd0, 0, 0, 32'h304, 6'd2);
      vecs[23] = mk(0, 32'h240, 1, 32'h200, 1, 32'h400, 0, 6'd0, 0, 0, 32'h244, 6'd2);
      vecs[24] = mk(1, 32'h240, 0, 32'h0,   0, 32'h0,   0, 6'd0, 0, 0, 32'h244, 6'd2);
      vecs[25] = mk(1, 32'h200, 0, 32'h0,   0, 32'h0,   0, 6'd0, 0, 1, 32'h400, 6'd2);
      vecs[26] = mk(1, 32'hFFFFFFFC, 0, 32'h0, 0, 32'h0, 0, 6'd0, 0, 0, 32'h0, 6'd2);
      vecs[27] = mk(1, 32'h108, 0, 32'h0,   0, 32'h0,   0, 6'd0, 0, 1, 32'h600, 6'd2);
      vecs[28] = mk(1, 32'h104, 0, 32'h0,   0, 32'h0,   0, 6'd0, 0, 1, 32'h500, 6'd2);

      reset = 1'b1;
      drive(mk(0, 32'h0, 0, 32'h0, 0, 32'h0, 0, 6'd0, 0, 0, 32'h0, 6'd0));
      repeat (2) @(negedge clock);
      reset = 1'b0;

      for (int i = 0; i < 29; i++) begin
         @(negedge clock);
         drive(vecs[i]);
         #2;
         check_outs($sformatf("vec%0d", i), vecs[i].et, vecs[i].etgt, vecs[i].eg);
      end

      // Reset mid-stream while a mispredict and a conditional prediction are also presented
      @(negedge clock);
      reset = 1'b1;
      drive(mk(1, 32'h200, 1, 32'h104, 1, 32'h700, 0, 6'h3F, 1, 0, 32'h0, 6'd0));
      @(negedge clock);
      reset = 1'b0;
      drive(mk(1, 32'h200, 0, 32'h0, 0, 32'h0, 0, 6'd0, 0, 0, 32'h0, 6'd0));
      #2;
      check_outs("rst_200", 1'b0, 32'h204, 6'd0);
      @(negedge clock);
      drive(mk(1, 32'h104, 0, 32'h0, 0, 32'h0, 0, 6'd0, 0, 0, 32'h0, 6'd0));
      #2;
      check_outs("rst_104", 1'b0, 32'h108, 6'd0);
      @(negedge clock);
      drive(mk(0, 32'h300, 1, 32'h300, 1, 32'h280, 1, 6'd5, 0, 0, 32'h0, 6'd0));
      @(negedge clock);
      drive(mk(1, 32'h300, 0, 32'h0, 0, 32'h0, 0, 6'd0, 0, 0, 32'h0, 6'd0));
      #2;
      check_outs("rst_ctr", 1'b0, 32'h304, 6'd0);
      @(negedge clock);
      drive(mk(0, 32'h300, 0, 32'h0, 0, 32'h0, 0, 6'd0, 0, 0, 32'h0, 6'd0));
      #2;
      check("rst_ctr_ghr_after", {26'b0, bp_if.pred_ghr}, 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
Front-end direction/target predictor; the fetch-side counterpart of the combinational branch resolution unit.
- Fetch asks for a prediction each cycle. The execute/complete stage returns resolved outcomes (take, target, func class) that train the predictor.
- On a mispredict, the resolve stage restores the speculative global history from the checkpoint carried with the branch.
- Contents: gshare BHT of 2-bit saturating counters, plus a direct-mapped tagged BTB.

Parameters:
- BHT_ENTRIES, 64: number of 2-bit counters; power of 2.
- GHR_BITS, 6: global history length; equals log2(BHT_ENTRIES).
- BTB_ENTRIES, 16: number of direct-mapped BTB entries; power of 2.
- BTB_TAG_BITS, 8: stored tag width.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high.
- pred_valid  in  1  fetch presents pred_pc this cycle.
- pred_pc  in  32 (ADDR)  fetch PC.
- pred_taken  out  1  predicted taken.
- pred_target  out  32 (ADDR)  next-PC prediction.
- pred_ghr  out  GHR_BITS  history used for this prediction; travels with the branch as its checkpoint.
- resolve_valid  in  1  a control-flow instruction resolved this cycle.
- resolve_pc  in  32 (ADDR)  PC of the resolved instruction.
- resolve_taken  in  1  actual outcome; always 1 for JAL/JALR.
- resolve_target  in  32 (ADDR)  actual taken target.
- resolve_is_cond  in  1  1 for BEQ/BNE/BLT/BGE/BLTU/BGEU; 0 for JAL/JALR.
- resolve_ghr  in  GHR_BITS  checkpoint returned with the branch.
- resolve_mispredict  in  1  direction or target was wrong; restore history.

Behaviour:
- Indexing:
  - BHT index = pred_pc[GHR_BITS+1:2] XOR ghr.
  - BTB index = pc[log2(BTB_ENTRIES)+1:2].
  - BTB tag = pc[log2(BTB_ENTRIES)+2 +: BTB_TAG_BITS].
- Prediction (combinational, 0-cycle latency from current state):
  - hit = btb.valid && tag match.
  - pred_taken = hit && (!btb.is_cond || counter[1]).
  - pred_target = pred_taken ? btb.target : pred_pc + 4 (32-bit, wraps mod 2^32).
  - pred_ghr = current GHR.
  - With pred_valid=0, outputs are still driven but no state changes.
- Speculative history: at the clock edge, if pred_valid && hit && btb.is_cond, GHR <= {GHR[GHR_BITS-2:0], pred_taken}. Unconditional hits do not shift.
- Training: at the clock edge when resolve_valid.
  - Counter update (only when resolve_is_cond=1):
    - The counter at resolve_pc[GHR_BITS+1:2] XOR resolve_ghr is updated.
    - Taken: increment, saturating at 11. Not taken: decrement, saturating at 00.
  - BTB update:
    - If resolve_taken: write the entry with valid=1, tag, target=resolve_target, is_cond=resolve_is_cond. This overwrites any aliased entry.
    - Not-taken resolves never allocate or invalidate.
- Recovery: when resolve_valid && resolve_mispredict:
  - GHR <= resolve_is_cond ? {resolve_ghr[GHR_BITS-2:0], resolve_taken} : resolve_ghr.
  - This overrides any same-cycle speculative shift.
- Simultaneous predict and resolve to the same BHT/BTB slot: the prediction sees pre-update state (no bypass). The update lands at the edge.
- Reset (any cycle, including mid-operation): takes priority over every other update and applies next cycle.
  - All counters <= 01 (weakly not-taken).
  - All BTB valid <= 0.
  - GHR <= 0.
  - Outputs after reset: pred_taken=0, pred_target=pred_pc+4, pred_ghr=0.
- No handshake backpressure: the block accepts one prediction and one resolve per cycle, unconditionally.

Decomposition:
- Shared package (sys_defs):
  - BP_COUNTER enum {SNT=00, WNT=01, WT=10, ST=11}.
  - BTB_ENTRY struct {valid, tag, target (ADDR), is_cond}.
  - Default sizes as `defines.
  - Reuse the existing ADDR type.
- One sub-module: branch_btb. It holds the BTB array, provides a combinational read port (hit, target, is_cond) and a single synchronous write port, and clears on reset.
- The BHT and GHR stay in branch_predictor.

Test Plan:
1. Reset, then pred_pc=0x100, pred_valid=1 -> pred_taken=0, pred_target=0x104, pred_ghr=0. GHR stays 0 on the next cycle.
2. Resolve JAL: pc=0x200, target=0x400, taken=1, is_cond=0. Next cycle, predict 0x200 -> taken=1, target=0x400, and GHR is unchanged after the edge.
3. Resolve BEQ: pc=0x300, target=0x280, taken=1, ghr=0 (counter 01->10, BTB allocated). Then predict 0x300 with GHR=0 -> taken=1, target=0x280; GHR becomes 000001 on the next edge.
4. Saturation at pc=0x300, ghr=0:
   - Three not-taken resolves drive the counter 01->00->00.
   - One taken resolve -> 01; predict 0x300 -> taken=0, target=0x304.
   - Three further taken resolves -> 11.
5. Recovery:
   - Speculate GHR to 000111.
   - Resolve mispredict with resolve_ghr=000010, is_cond=1, taken=0, while pred_valid hits a conditional the same cycle.
   - Required: GHR=000100 next cycle.
   - Repeat with is_cond=0 -> GHR=000010.
6. Alias and edge cases:
   - Train a taken branch at 0x200, then predict 0x240 (same BTB index, different tag) -> taken=0, target=0x244.
   - pred_pc=0xFFFFFFFC on a miss -> pred_target=0x00000000.
   - Assert reset mid-stream -> entry 0x200 misses afterward.
